spu_regfile_mp: RTL

- Parametrised, clocked multi-port register file for the dual-issue SPU pipeline. Sits between decode and the execute pipes.
- Provides NUM_RD combinational read ports with same-cycle write-to-read bypass.
- Provides NUM_WR synchronous write-back ports with defined collision priority.
- Contains a sequential clear engine that zeroes the array after reset or on request, because the array itself is not reset.

---
 rtl/spu_regfile_mp.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spu_regfile_mp.sv
// Multi-port SPU register file with write-to-read bypass and a sequential clear engine.
// Optional parity storage and checking is enabled with `define SPU_REGFILE_PARITY_EN.
module spu_regfile_mp #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned NUM_RD   = 6,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     ready,
  output logic                     wr_conflict,
  output logic                     wr_dropped,
  output logic [NUM_RD-1:0]        rd_perr
);

  localparam int unsigned LAST_REG = NUM_REGS - 1;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
  logic              same_addr_c;

  // Storage is intentionally not reset; the clear engine initialises it.
  logic [DATA_W-1:0] mem [NUM_REGS];
`ifdef SPU_REGFILE_PARITY_EN
  logic              mem_par [NUM_REGS];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CLEAR;
      clr_ptr     <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
      wr_dropped  <= 1'b0;
    end else begin
      state       <= state_next;
      clr_ptr     <= clr_ptr_next;
      ready       <= (state_next == S_READY);
      wr_conflict <= (state == S_READY) && same_addr_c;
      wr_dropped  <= (state == S_CLEAR) && (|wr_en);
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      S_CLEAR: begin
        clr_ptr_next = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(LAST_REG)) begin
          state_next   = S_READY;
          clr_ptr_next = '0;
        end
      end
      S_READY: begin
        if (clear_req) begin
          state_next   = S_CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Any pair of enabled write ports aimed at the same entry.
  always_comb begin
    same_addr_c = 1'b0;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      for (int j = i + 1; j < int'(NUM_WR); j++) begin
        if (wr_en[i] && wr_en[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          same_addr_c = 1'b1;
        end
      end
    end
  end

  // Ascending port order lets the highest-indexed port win a collision.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_ptr] <= '0;
`ifdef SPU_REGFILE_PARITY_EN
      mem_par[clr_ptr] <= 1'b0;
`endif
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j]) begin
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
`ifdef SPU_REGFILE_PARITY_EN
          mem_par[wr_addr[j*ADDR_W +: ADDR_W]] <= ^wr_data[j*DATA_W +: DATA_W];
`endif
        end
      end
    end
  end

  // Zero-latency reads with same-cycle bypass from the write ports.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;
    logic              hit;
    rd_data = '0;
    rd_perr = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra   = rd_addr[i*ADDR_W +: ADDR_W];
      word = mem[ra];
      hit  = 1'b0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
          word = wr_data[j*DATA_W +: DATA_W];
          hit  = 1'b1;
        end
      end
      if (state == S_READY) begin
        rd_data[i*DATA_W +: DATA_W] = word;
`ifdef SPU_REGFILE_PARITY_EN
        rd_perr[i] = !hit && (mem_par[ra] != (^mem[ra]));
`endif
      end
    end
  end

endmodule
